// File: rtl/request_tag_manager_if.sv
// Handshake bundle between the request mapper, the response path and the tag manager.
// The master side issues allocations and releases; the slave side is the tag manager.
interface request_tag_manager_if #(
    parameter int TAG_W = 5,
    parameter int REC_W = 64
);
    logic             alloc_req;
    logic [REC_W-1:0] alloc_data;
    logic             alloc_gnt;
    logic [TAG_W-1:0] alloc_tag;
    logic             rec_wr_en;
    logic [TAG_W-1:0] rec_wr_addr;
    logic [REC_W-1:0] rec_wr_data;
    logic             rel_valid;
    logic [TAG_W-1:0] rel_tag;
    logic [TAG_W:0]   free_cnt;
    logic             all_idle;
    logic             rel_err;

    modport master (
        output alloc_req, alloc_data, rel_valid, rel_tag,
        input  alloc_gnt, alloc_tag, rec_wr_en, rec_wr_addr, rec_wr_data,
        input  free_cnt, all_idle, rel_err
    );

    modport slave (
        input  alloc_req, alloc_data, rel_valid, rel_tag,
        output alloc_gnt, alloc_tag, rec_wr_en, rec_wr_addr, rec_wr_data,
        output free_cnt, all_idle, rel_err
    );
endinterface

// File: rtl/request_tag_manager.sv
// Tag allocator for non-posted requests: busy bitmap, lowest-free-tag grant,
// registered recorder write port and release checking.
module request_tag_manager #(
    parameter int NUM_TAGS = 32,
    parameter int TAG_W    = 5,
    parameter int REC_W    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    request_tag_manager_if.slave  bus
);
    logic [NUM_TAGS-1:0] busy_reg;
    logic [NUM_TAGS-1:0] busy_next;
    logic [TAG_W:0]      free_cnt_reg;
    logic [TAG_W:0]      free_cnt_next;
    logic                rec_wr_en_reg;
    logic [TAG_W-1:0]    rec_wr_addr_reg;
    logic [REC_W-1:0]    rec_wr_data_reg;
    logic                rel_err_reg;

    logic                alloc_gnt;
    logic [TAG_W-1:0]    alloc_tag;
    logic                alloc_fire;
    logic                rel_hit;
    logic                rel_legal;
    logic                rel_illegal;

    assign alloc_gnt  = (free_cnt_reg != '0);
    assign alloc_fire = bus.alloc_req && alloc_gnt;

    // Lowest clear bit wins; scanning downward lets the last match be the lowest.
    always_comb begin
        alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_reg[i]) begin
                alloc_tag = TAG_W'(i);
            end
        end
    end

    assign rel_hit     = busy_reg[bus.rel_tag];
    assign rel_legal   = bus.rel_valid && rel_hit;
    assign rel_illegal = bus.rel_valid && !rel_hit;

    // The granted tag is always clear and a legal release tag is always set,
    // so a same-cycle set and clear never target the same bit.
    generate
        for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit       = alloc_fire && (alloc_tag == TAG_W'(gi));
            assign clr_bit       = rel_legal && (bus.rel_tag == TAG_W'(gi));
            assign busy_next[gi] = set_bit ? 1'b1 : (clr_bit ? 1'b0 : busy_reg[gi]);
        end
    endgenerate

    always_comb begin
        free_cnt_next = free_cnt_reg;
        case ({alloc_fire, rel_legal})
            2'b10:   free_cnt_next = free_cnt_reg - (TAG_W+1)'(1);
            2'b01:   free_cnt_next = free_cnt_reg + (TAG_W+1)'(1);
            default: free_cnt_next = free_cnt_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg        <= '0;
            free_cnt_reg    <= (TAG_W+1)'(NUM_TAGS);
            rec_wr_en_reg   <= 1'b0;
            rec_wr_addr_reg <= '0;
            rec_wr_data_reg <= '0;
            rel_err_reg     <= 1'b0;
        end else begin
            busy_reg      <= busy_next;
            free_cnt_reg  <= free_cnt_next;
            rec_wr_en_reg <= alloc_fire;
            rel_err_reg   <= rel_illegal;
            if (alloc_fire) begin
                rec_wr_addr_reg <= alloc_tag;
                rec_wr_data_reg <= bus.alloc_data;
            end
        end
    end

    assign bus.alloc_gnt   = alloc_gnt;
    assign bus.alloc_tag   = alloc_tag;
    assign bus.rec_wr_en   = rec_wr_en_reg;
    assign bus.rec_wr_addr = rec_wr_addr_reg;
    assign bus.rec_wr_data = rec_wr_data_reg;
    assign bus.free_cnt    = free_cnt_reg;
    assign bus.all_idle    = (free_cnt_reg == (TAG_W+1)'(NUM_TAGS));
    assign bus.rel_err     = rel_err_reg;

endmodule

// File: doc/request_tag_manager.md
REQUEST_TAG_MANAGER -- requirements
Module: request_tag_manager

Interface
REQ-001 SHALL have parameter NUM_TAGS, default 32, number of request recorder slots (power of two, 4..256).
REQ-002 SHALL have parameter TAG_W, default 5, tag width = log2(NUM_TAGS).
REQ-003 SHALL have parameter REC_W, default 64, request recorder entry width.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  input  1  the clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port alloc_req  input  1  the mapper requests a tag for a new non-posted request.
REQ-008 SHALL have port alloc_data  input  REC_W  the request record to store, valid with alloc_req.
REQ-009 SHALL have port alloc_gnt  output  1  a tag is available; allocation happens when alloc_req and alloc_gnt are both high.
REQ-010 SHALL have port alloc_tag  output  TAG_W  the tag being granted, valid while alloc_gnt is high.
REQ-011 SHALL have port rec_wr_en  output  1  write strobe to the recorder request write port.
REQ-012 SHALL have port rec_wr_addr  output  TAG_W  recorder write address (the tag).
REQ-013 SHALL have port rec_wr_data  output  REC_W  recorder write data.
REQ-014 SHALL have port rel_valid  input  1  the response path retires a tag.
REQ-015 SHALL have port rel_tag  input  TAG_W  the tag to retire, valid with rel_valid.
REQ-016 SHALL have port free_cnt  output  TAG_W+1  number of free tags.
REQ-017 SHALL have port all_idle  output  1  high when no tag is outstanding.
REQ-018 SHALL have port rel_err  output  1  one-cycle pulse for an illegal release.

Function
REQ-019 SHALL keep a NUM_TAGS-bit busy bitmap, where bit i set means tag i is outstanding.
REQ-020 SHALL drive alloc_gnt = (free_cnt != 0) combinationally from registered state, and SHALL NOT make it depend on alloc_req.
REQ-021 SHALL drive alloc_tag as the lowest-index clear bit of the bitmap (fixed-priority encoder); when no bit is clear, alloc_tag = 0.
REQ-022 On an allocation, SHALL set busy[alloc_tag] at the next edge.
REQ-023 On an allocation, SHALL register rec_wr_en=1, rec_wr_addr=alloc_tag and rec_wr_data=alloc_data, giving exactly 1 cycle of latency.
REQ-024 In any cycle with no allocation, SHALL register rec_wr_en=0 and hold rec_wr_addr and rec_wr_data.
REQ-025 On rel_valid with busy[rel_tag]=1, SHALL clear busy[rel_tag] at the next edge.
REQ-026 On rel_valid with busy[rel_tag]=0, SHALL change no state and SHALL drive rel_err=1 for the next cycle only.
REQ-027 On simultaneous allocation and legal release, SHALL apply both updates; free_cnt stays unchanged.
REQ-028 On simultaneous allocation and legal release, the released tag SHALL become grantable only from the following cycle (allocation uses pre-release state).
REQ-029 SHALL update free_cnt as: +1 on legal release only, -1 on allocation only, unchanged otherwise; free_cnt never leaves 0..NUM_TAGS.
REQ-030 When full (free_cnt=0), SHALL hold alloc_gnt=0, and alloc_req SHALL change no state.
REQ-031 SHALL drive all_idle = (free_cnt == NUM_TAGS), from registered state.
REQ-032 SHALL meet: bitmap popcount + free_cnt == NUM_TAGS at every edge.

Reset
REQ-033 With rst high at an edge, SHALL clear the bitmap and set free_cnt=NUM_TAGS, rec_wr_en=0, rec_wr_addr=0, rec_wr_data=0, rel_err=0.
REQ-034 Reset SHALL take priority over a simultaneous allocation or release; both are dropped and no recorder write is issued.
REQ-035 In the first cycle after reset, SHALL present alloc_gnt=1, alloc_tag=0 and all_idle=1.

Verification
REQ-036 Reset then 32 back-to-back allocations -> tags 0,1,...,31 in order; rec_wr_en follows each grant by 1 cycle with matching addr/data; after the 32nd, alloc_gnt=0 and free_cnt=0.
REQ-037 While full, release tag 7 -> next cycle free_cnt=1, alloc_gnt=1, alloc_tag=7.
REQ-038 With tags 0..3 busy, release tag 1 and allocate in the same cycle -> grant is tag 4, tag 1 is free next cycle, free_cnt unchanged.
REQ-039 Release tag 9 while tag 9 is free -> rel_err=1 for exactly one cycle; bitmap and free_cnt unchanged.
REQ-040 Assert rst in the same cycle as alloc_req and rel_valid with 10 tags busy -> next cycle free_cnt=32, all_idle=1, rec_wr_en=0.
REQ-041 Random alloc/release for 10k cycles -> REQ-032 holds every cycle and no tag is granted twice while outstanding.
